// File: rtl/conv_channel_accum.sv
`default_nettype none
// ============================================================================
// conv_channel_accum : per-pixel channel accumulator with bias, ReLU and clamp
// Revision 1.0
// ============================================================================
module conv_channel_accum #(
    parameter int ACC_W = 48,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [37:0]      in_sum,
    input  logic             in_last,
    input  logic [31:0]      bias,
    input  logic             relu_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat,
    output logic [15:0]      group_cnt
);

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        BIAS  = 2'd1,
        SAT   = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    first_q, first_d;
    logic signed [31:0]      bias_q, bias_d;
    logic                    relu_q, relu_d;
    logic signed [ACC_W:0]   biased_q, biased_d;
    logic [OUT_W-1:0]        out_data_q, out_data_d;
    logic                    out_sat_q, out_sat_d;
    logic                    out_valid_q, out_valid_d;
    logic [15:0]             group_cnt_q, group_cnt_d;

    logic signed [ACC_W-1:0]   sum_ext;
    logic [ACC_W-OUT_W+1:0]    biased_hi;
    logic                      fits;

    assign sum_ext   = ACC_W'($signed(in_sum));
    // Result fits OUT_W iff every bit above the output sign bit matches it
    assign biased_hi = biased_q[ACC_W:OUT_W-1];
    assign fits      = (&biased_hi) | ~(|biased_hi);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            first_q     <= 1'b1;
            bias_q      <= '0;
            relu_q      <= 1'b0;
            biased_q    <= '0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            out_valid_q <= 1'b0;
            group_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            first_q     <= first_d;
            bias_q      <= bias_d;
            relu_q      <= relu_d;
            biased_q    <= biased_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            out_valid_q <= out_valid_d;
            group_cnt_q <= group_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        first_d     = first_q;
        bias_d      = bias_q;
        relu_d      = relu_q;
        biased_d    = biased_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        out_valid_d = out_valid_q;
        group_cnt_d = group_cnt_q;
        case (state_q)
            ACCUM: begin
                if (in_valid) begin
                    acc_d   = first_q ? sum_ext : acc_q + sum_ext;
                    first_d = 1'b0;
                    if (in_last) begin
                        bias_d  = bias;
                        relu_d  = relu_en;
                        state_d = BIAS;
                    end
                end
            end
            BIAS: begin
                biased_d = (ACC_W+1)'(acc_q) + (ACC_W+1)'(bias_q);
                state_d  = SAT;
            end
            SAT: begin
                if (relu_q && biased_q[ACC_W]) begin
                    out_data_d = '0;
                    out_sat_d  = 1'b0;
                end else if (!fits) begin
                    out_data_d = biased_q[ACC_W] ? {1'b1, {(OUT_W-1){1'b0}}}
                                                 : {1'b0, {(OUT_W-1){1'b1}}};
                    out_sat_d  = 1'b1;
                end else begin
                    out_data_d = biased_q[OUT_W-1:0];
                    out_sat_d  = 1'b0;
                end
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    group_cnt_d = group_cnt_q + 16'd1;
                    first_d     = 1'b1;
                    state_d     = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign group_cnt = group_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_channel_accum.sv
`default_nettype none
// ============================================================================
// tb_conv_channel_accum : randomized + directed bench against a sum-based model
// Revision 1.0
// ============================================================================
module tb_conv_channel_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [37:0] in_sum;
    logic        in_last;
    logic [31:0] bias;
    logic        relu_en;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_sat;
    logic [15:0] group_cnt;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_cnt  = '0;
    logic [37:0] beats[$];

    always #5 clk = ~clk;

    conv_channel_accum #(.ACC_W(48), .OUT_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_last   (in_last),
        .bias      (bias),
        .relu_en   (relu_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .group_cnt (group_cnt)
    );

    // Reference: exact integer sum of the group plus bias, then ReLU / clamp
    function automatic void ref_out(input longint sum, input logic [31:0] b, input logic r,
                                    output logic [31:0] d, output logic s);
        longint v;
        v = sum + longint'($signed(b));
        s = 1'b0;
        if (r && v < 0)                  d = 32'h0;
        else if (v > 64'sd2147483647)  begin d = 32'h7FFFFFFF; s = 1'b1; end
        else if (v < -64'sd2147483648) begin d = 32'h80000000; s = 1'b1; end
        else                             d = v[31:0];
    endfunction

    // Sends the queued beats; lat counts edges with the in_last accept edge as 1
    task automatic send_group(input logic [31:0] b, input logic r, input bit gaps,
                              output int lat, output longint sum);
        sum = 0;
        for (int i = 0; i < beats.size(); i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0; in_last = 1'b1; in_sum = 38'($urandom);
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_sum   = beats[i];
            in_last  = (i == beats.size() - 1);
            bias     = in_last ? b : $urandom;
            relu_en  = in_last ? r : 1'($urandom);
            sum     += longint'($signed(beats[i]));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_cnt   = exp_cnt + 16'd1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_sum = '0; in_last = 1'b0;
        bias = '0; relu_en = 1'b0; out_ready = 1'b0;
        #12;
        checks++; if (out_valid !== 1'b0)   begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 32'h0)   begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        checks++; if (out_sat !== 1'b0)     begin failures++; $display("FAIL reset_out_sat got=%b exp=0", out_sat); end
        checks++; if (group_cnt !== 16'h0)  begin failures++; $display("FAIL reset_group_cnt got=%h exp=0", group_cnt); end
        @(posedge clk); #3; rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1)    begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        exp_cnt = '0;
    endtask

    task automatic test_accumulation();
        int lat; longint sum;
        beats = '{38'h0010000, 38'h0020000, 38'h3FFFFF8000};
        send_group(32'h00004000, 1'b0, 1'b0, lat, sum);
        checks++; if (lat != 3)                 begin failures++; $display("FAIL accum_latency got=%0d exp=3", lat); end
        checks++; if (out_data !== 32'h0002C000) begin failures++; $display("FAIL accum_data got=%h exp=0002c000", out_data); end
        checks++; if (out_sat !== 1'b0)         begin failures++; $display("FAIL accum_sat got=%b exp=0", out_sat); end
        handshake();
    endtask

    task automatic test_relu();
        int lat; longint sum;
        beats = '{38'h3FFFFD0000};
        send_group(32'h00010000, 1'b1, 1'b0, lat, sum);
        checks++; if (out_data !== 32'h0 || out_sat !== 1'b0)
            begin failures++; $display("FAIL relu got=%h/%b exp=00000000/0", out_data, out_sat); end
        handshake();
    endtask

    task automatic test_saturation();
        int lat; longint sum;
        beats = '{38'h1000000000, 38'h1000000000};
        send_group(32'h0, 1'b0, 1'b0, lat, sum);
        checks++; if (out_data !== 32'h7FFFFFFF || out_sat !== 1'b1)
            begin failures++; $display("FAIL sat_pos got=%h/%b exp=7fffffff/1", out_data, out_sat); end
        handshake();
        beats = '{38'h3000000000, 38'h3000000000};
        send_group(32'h0, 1'b0, 1'b0, lat, sum);
        checks++; if (out_data !== 32'h80000000 || out_sat !== 1'b1)
            begin failures++; $display("FAIL sat_neg got=%h/%b exp=80000000/1", out_data, out_sat); end
        handshake();
    endtask

    task automatic test_backpressure();
        int lat; longint sum; logic [31:0] d; logic s; logic [31:0] held;
        beats = '{38'h0030000};
        send_group(32'h0, 1'b0, 1'b0, lat, sum);
        held = out_data;
        checks++; if (held !== 32'h00030000) begin failures++; $display("FAIL bp_data got=%h exp=00030000", held); end
        in_valid = 1'b1; in_sum = 38'h0100000; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_data !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d data=%h valid=%b in_ready=%b exp=%h/1/0",
                         i, out_data, out_valid, in_ready, held);
            end
        end
        in_valid = 1'b0; in_last = 1'b0;
        handshake();
        checks++; if (group_cnt !== exp_cnt) begin failures++; $display("FAIL bp_cnt got=%h exp=%h", group_cnt, exp_cnt); end
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            begin failures++; $display("FAIL bp_release in_ready=%b out_valid=%b exp=1/0", in_ready, out_valid); end
        beats = '{38'h0008000};
        send_group(32'h0, 1'b0, 1'b0, lat, sum);
        ref_out(sum, 32'h0, 1'b0, d, s);
        checks++; if (out_data !== d) begin failures++; $display("FAIL bp_next got=%h exp=%h", out_data, d); end
        handshake();
    endtask

    task automatic test_random();
        int lat; longint sum; logic [31:0] b; logic r; logic [31:0] d; logic s;
        logic [23:0] s24;
        for (int g = 0; g < 25; g++) begin
            beats.delete();
            for (int k = 0; k < $urandom_range(1, 8); k++) begin
                s24 = 24'($urandom);
                if ($urandom_range(0, 3) == 0) beats.push_back({6'($urandom), 32'($urandom)});
                else                            beats.push_back({{14{s24[23]}}, s24});
            end
            b = $urandom;
            r = 1'($urandom);
            send_group(b, r, 1'b1, lat, sum);
            ref_out(sum, b, r, d, s);
            checks++;
            if (lat != 3 || out_data !== d || out_sat !== s) begin
                failures++;
                $display("FAIL random g=%0d lat=%0d data=%h sat=%b exp=3/%h/%b", g, lat, out_data, out_sat, d, s);
            end
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            handshake();
            checks++; if (group_cnt !== exp_cnt) begin failures++; $display("FAIL random_cnt got=%h exp=%h", group_cnt, exp_cnt); end
        end
    endtask

    task automatic test_midreset();
        int lat; longint sum;
        beats = '{38'h0050000};
        send_group(32'h0, 1'b0, 1'b0, lat, sum);
        #2 rst = 1'b1; #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_sat !== 1'b0 || group_cnt !== 16'h0) begin
            failures++;
            $display("FAIL midreset_pending valid=%b data=%h sat=%b cnt=%h exp=0", out_valid, out_data, out_sat, group_cnt);
        end
        @(posedge clk); #3 rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_sum = 38'h0070000; in_last = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #2 rst = 1'b1; #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_sat !== 1'b0 || group_cnt !== 16'h0) begin
            failures++;
            $display("FAIL midreset_outputs valid=%b data=%h sat=%b cnt=%h exp=0", out_valid, out_data, out_sat, group_cnt);
        end
        @(posedge clk); #3 rst = 1'b0;
        @(posedge clk); #1;
        exp_cnt = '0;
        beats = '{38'h0010000};
        send_group(32'h0, 1'b0, 1'b0, lat, sum);
        checks++; if (out_data !== 32'h00010000) begin failures++; $display("FAIL midreset_next got=%h exp=00010000", out_data); end
        handshake();
        checks++; if (group_cnt !== 16'h1) begin failures++; $display("FAIL midreset_cnt got=%h exp=0001", group_cnt); end
    endtask

    initial begin
        test_reset();
        test_accumulation();
        test_relu();
        test_saturation();
        test_backpressure();
        test_random();
        test_midreset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
